ecc_apb_job_sequencer: RTL and testbench

//  Sequences jobs from NUM_REQ requesters onto the single APB-attached ECC encoder/decoder core.

---
 rtl/ecc_apb_job_sequencer_if.sv | 50 +++++
 rtl/ecc_apb_job_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_ecc_apb_job_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_apb_job_sequencer_if.sv
// Signal bundle for ecc_apb_job_sequencer: requester jobs, tagged responses,
// APB-master bus and ECC core status. "master" is the sequencer, "slave" its environment.
interface ecc_apb_job_sequencer_if #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int NUM_REQ         = 2
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [2*NUM_REQ-1:0]         req_op;
  logic [2*NUM_REQ-1:0]         req_width;
  logic [AMBA_WORD*NUM_REQ-1:0] req_data;
  logic [AMBA_WORD*NUM_REQ-1:0] req_noise;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [AMBA_WORD-1:0]         rsp_data;
  logic [1:0]                   rsp_num_err;
  logic                         rsp_err;
  logic                         rsp_timeout;
  logic                         busy;

  logic [AMBA_ADDR_WIDTH-1:0]   PADDR;
  logic [AMBA_WORD-1:0]         PWDATA;
  logic                         PSEL;
  logic                         PENABLE;
  logic                         PWRITE;
  logic [AMBA_WORD-1:0]         PRDATA;

  logic [AMBA_WORD-1:0]         data_out;
  logic                         operation_done;
  logic [1:0]                   num_of_errors;

  modport master (
    input  req_valid, req_op, req_width, req_data, req_noise, rsp_ready,
           PRDATA, data_out, operation_done, num_of_errors,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_num_err, rsp_err, rsp_timeout,
           busy, PADDR, PWDATA, PSEL, PENABLE, PWRITE
  );

  modport slave (
    output req_valid, req_op, req_width, req_data, req_noise, rsp_ready,
           PRDATA, data_out, operation_done, num_of_errors,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_num_err, rsp_err, rsp_timeout,
           busy, PADDR, PWDATA, PSEL, PENABLE, PWRITE
  );
endinterface

// File: rtl/ecc_apb_job_sequencer.sv
// Round-robin job sequencer driving an APB-attached ECC core: program, start, wait, respond.
// Define ECC_SEQ_READBACK_EN to verify DATA_IN by an APB read before the CTRL write.
module ecc_apb_job_sequencer #(
  parameter int          AMBA_ADDR_WIDTH = 20,
  parameter int          AMBA_WORD       = 32,
  parameter int          NUM_REQ         = 2,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int          TIMEOUT_CYCLES  = 16
) (
  input logic                     clk,
  input logic                     rst,
  ecc_apb_job_sequencer_if.master bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [AMBA_ADDR_WIDTH-1:0] addr_t;
  localparam addr_t ADDR_CTRL  = addr_t'(BASE_ADDR);
  localparam addr_t ADDR_DATA  = addr_t'(BASE_ADDR + 32'h4);
  localparam addr_t ADDR_WIDTH = addr_t'(BASE_ADDR + 32'h8);
  localparam addr_t ADDR_NOISE = addr_t'(BASE_ADDR + 32'hC);

  typedef enum logic [2:0] {S_IDLE, S_APB_SETUP, S_APB_ACCESS, S_WAIT_DONE, S_RESP} state_e;
  typedef enum logic [2:0] {X_DATA, X_WIDTH, X_NOISE, X_READ, X_CTRL} step_e;

  state_e               state_q, state_d;
  step_e                step_q, step_d;
  logic [ID_W-1:0]      ptr_q, ptr_d, id_q, id_d;
  logic [1:0]           op_q, op_d, width_q, width_d;
  logic [AMBA_WORD-1:0] data_q, data_d, noise_q, noise_d;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic [AMBA_WORD-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]           rsp_nerr_q, rsp_nerr_d;
  logic                 rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;

  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]   req_ready_c;
  logic                 psel, penable, pwrite;
  addr_t                paddr;
  logic [AMBA_WORD-1:0] pwdata;

  // First pending requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready_c = '0;
    if (state_q == S_IDLE && grant_found) req_ready_c[grant_idx] = 1'b1;
  end

  // NOTE: every signal written here gets its hold/default value first, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    width_d    = width_q;
    data_d     = data_q;
    noise_d    = noise_q;
    wait_d     = wait_q;
    rsp_data_d = rsp_data_q;
    rsp_nerr_d = rsp_nerr_q;
    rsp_err_d  = rsp_err_q;
    rsp_to_d   = rsp_to_q;
    case (state_q)
      S_IDLE: if (grant_found) begin
        id_d       = grant_idx;
        op_d       = bus.req_op[2*grant_idx +: 2];
        width_d    = bus.req_width[2*grant_idx +: 2];
        data_d     = bus.req_data[AMBA_WORD*grant_idx +: AMBA_WORD];
        noise_d    = bus.req_noise[AMBA_WORD*grant_idx +: AMBA_WORD];
        ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        step_d     = X_DATA;
        rsp_data_d = '0;
        rsp_nerr_d = '0;
        rsp_err_d  = 1'b0;
        rsp_to_d   = 1'b0;
        if (bus.req_op[2*grant_idx +: 2] == 2'b11) begin
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          state_d = S_APB_SETUP;
        end
      end
      S_APB_SETUP: state_d = S_APB_ACCESS;
      S_APB_ACCESS: begin
        state_d = S_APB_SETUP;
        case (step_q)
          X_DATA:  step_d = X_WIDTH;
          X_WIDTH: step_d = X_NOISE;
`ifdef ECC_SEQ_READBACK_EN
          X_NOISE: step_d = X_READ;
          X_READ: begin
            if (bus.PRDATA != data_q) begin
              rsp_err_d = 1'b1;
              state_d   = S_RESP;
            end else begin
              step_d = X_CTRL;
            end
          end
`else
          X_NOISE: step_d = X_CTRL;
`endif
          X_CTRL: begin
            state_d = S_WAIT_DONE;
            wait_d  = '0;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_WAIT_DONE: begin
        // The done level may still be left over from the previous job on the first cycle.
        if (wait_q != '0 && bus.operation_done) begin
          rsp_data_d = bus.data_out;
          rsp_nerr_d = (op_q == 2'b00) ? 2'b00 : bus.num_of_errors;
          state_d    = S_RESP;
        end else if (wait_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_to_d = 1'b1;
          state_d  = S_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make all flops update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= X_DATA;
      ptr_q      <= '0;
      id_q       <= '0;
      op_q       <= '0;
      width_q    <= '0;
      data_q     <= '0;
      noise_q    <= '0;
      wait_q     <= '0;
      rsp_data_q <= '0;
      rsp_nerr_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      width_q    <= width_d;
      data_q     <= data_d;
      noise_q    <= noise_d;
      wait_q     <= wait_d;
      rsp_data_q <= rsp_data_d;
      rsp_nerr_q <= rsp_nerr_d;
      rsp_err_q  <= rsp_err_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  // APB bus decoded straight from state so a reset drops PSEL/PENABLE without waiting for a clock.
  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    if (state_q == S_APB_SETUP || state_q == S_APB_ACCESS) begin
      psel    = 1'b1;
      penable = (state_q == S_APB_ACCESS);
      pwrite  = 1'b1;
      case (step_q)
        X_DATA:  begin paddr = ADDR_DATA;  pwdata = data_q;                  end
        X_WIDTH: begin paddr = ADDR_WIDTH; pwdata = AMBA_WORD'(width_q);     end
        X_NOISE: begin paddr = ADDR_NOISE; pwdata = noise_q;                 end
        X_READ:  begin paddr = ADDR_DATA;  pwrite = 1'b0;                    end
        X_CTRL:  begin paddr = ADDR_CTRL;  pwdata = AMBA_WORD'(op_q);        end
        default: ;
      endcase
    end
  end

`ifndef ECC_SEQ_READBACK_EN
  logic unused_prdata;
  assign unused_prdata = ^bus.PRDATA;
`endif

  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_num_err = rsp_nerr_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PWRITE      = pwrite;
  assign bus.PADDR       = paddr;
  assign bus.PWDATA      = pwdata;
endmodule

// File: tb/tb_ecc_apb_job_sequencer.sv
// Directed bench for ecc_apb_job_sequencer: a table of single jobs with cycle-exact
// APB/response expectations, plus round-robin, response stall and mid-transfer reset sequences.
module tb_ecc_apb_job_sequencer;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int NR = 2;
`ifdef ECC_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int C     = RB ? 10 : 8;   // CTRL ACCESS cycle after accept at cycle 0
  localparam int NEVER = 999;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecc_apb_job_sequencer_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .NUM_REQ(NR)) bus ();

  ecc_apb_job_sequencer #(
    .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .NUM_REQ(NR), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [1:0]  width;
    logic [31:0] data;
    logic [31:0] noise;
    logic [31:0] prdata;
    logic [31:0] core_out;
    logic [1:0]  core_nerr;
    int          done_cyc;
    int          exp_resp;
    logic [31:0] exp_data;
    logic [1:0]  exp_nerr;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs [7];
  int   n_checks;
  int   n_errors;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_num_err,
            bus.rsp_err, bus.rsp_timeout, bus.busy, bus.PADDR, bus.PWDATA,
            bus.PSEL, bus.PENABLE, bus.PWRITE};
  endfunction

  task automatic wait_idle(input string name);
    for (int c = 0; c < 60 && bus.busy; c++) @(negedge clk);
    check(name, bus.busy, 1'b0);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    logic [AW-1:0] ex_addr [5];
    logic [DW-1:0] ex_wd   [5];
    logic          ex_wr   [5];
    logic [NR-1:0] exp_rdy;
    int nx, resp_cyc, apb_bad, k;
    ex_addr[0] = 20'h4; ex_wd[0] = v.data;            ex_wr[0] = 1'b1;
    ex_addr[1] = 20'h8; ex_wd[1] = {30'd0, v.width};  ex_wr[1] = 1'b1;
    ex_addr[2] = 20'hC; ex_wd[2] = v.noise;           ex_wr[2] = 1'b1;
    if (RB) begin
      ex_addr[3] = 20'h4; ex_wd[3] = '0;             ex_wr[3] = 1'b0;
      ex_addr[4] = 20'h0; ex_wd[4] = {30'd0, v.op};  ex_wr[4] = 1'b1;
    end else begin
      ex_addr[3] = 20'h0; ex_wd[3] = {30'd0, v.op};  ex_wr[3] = 1'b1;
      ex_addr[4] = 20'h0; ex_wd[4] = '0;             ex_wr[4] = 1'b0;
    end
    if (v.op == 2'b11)                 nx = 0;
    else if (RB && v.prdata != v.data) nx = 4;
    else if (RB)                       nx = 5;
    else                               nx = 4;

    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.req_valid[v.id] = 1'b1;
    bus.req_op[2*v.id +: 2]     = v.op;
    bus.req_width[2*v.id +: 2]  = v.width;
    bus.req_data[DW*v.id +: DW] = v.data;
    bus.req_noise[DW*v.id +: DW] = v.noise;
    bus.data_out       = v.core_out;
    bus.num_of_errors  = v.core_nerr;
    bus.PRDATA         = v.prdata;
    bus.operation_done = 1'b0;
    @(negedge clk);
    exp_rdy = '0;
    exp_rdy[v.id] = 1'b1;
    check($sformatf("v%0d req_ready", vi), bus.req_ready, exp_rdy);

    resp_cyc = -1;
    apb_bad  = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      bus.req_valid      = '0;
      bus.operation_done = (c >= v.done_cyc);
      @(negedge clk);
      if (c <= 2*nx) begin
        k = (c - 1) / 2;
        if (!bus.PSEL || bus.PENABLE != (c % 2 == 0) || bus.PADDR != ex_addr[k] ||
            bus.PWRITE != ex_wr[k] || (ex_wr[k] && bus.PWDATA != ex_wd[k]))
          apb_bad++;
      end else if (bus.PSEL || bus.PENABLE) begin
        apb_bad++;
      end
      if (bus.rsp_valid) begin
        resp_cyc = c;
        break;
      end
    end
    check($sformatf("v%0d apb_trace_errs", vi), apb_bad, 0);
    check($sformatf("v%0d resp_cycle", vi), resp_cyc, v.exp_resp);
    check($sformatf("v%0d rsp_id", vi), bus.rsp_id, v.id);
    check($sformatf("v%0d rsp_data", vi), bus.rsp_data, v.exp_data);
    check($sformatf("v%0d rsp_num_err", vi), bus.rsp_num_err, v.exp_nerr);
    check($sformatf("v%0d rsp_err", vi), bus.rsp_err, v.exp_err);
    check($sformatf("v%0d rsp_timeout", vi), bus.rsp_timeout, v.exp_to);
  endtask

  task automatic rr_test();
    logic [3:0]    gbits;
    logic [NR-1:0] prev_rdy;
    int ng, bad;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    bus.req_op    = {2'b01, 2'b01};
    bus.req_width = {2'b10, 2'b00};
    bus.req_data  = {32'h0000_1111, 32'h0000_2222};
    bus.req_noise = {32'h1, 32'h2};
    bus.PRDATA    = 32'h0;
    bus.operation_done = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    ng = 0; bad = 0; gbits = '0; prev_rdy = '0;
    for (int c = 0; c < 150 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        if (!$onehot(bus.req_ready) || bus.busy || prev_rdy != '0) bad++;
        gbits[ng] = bus.req_ready[1];
        ng++;
      end
      prev_rdy = bus.req_ready;
    end
    check("rr_grant_count", ng, 4);
    check("rr_grant_order", gbits, 4'b1010);
    check("rr_ready_pulse_errs", bad, 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle("rr_final_idle");
  endtask

  task automatic stall_test();
    logic [127:0] snap;
    int seen, bad;
    @(posedge clk); #1;
    bus.req_op    = {2'b01, 2'b01};
    bus.req_data  = {32'h0000_2468, 32'h0000_1357};
    bus.data_out  = 32'h0000_600D;
    bus.num_of_errors  = 2'd1;
    bus.operation_done = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("stall_accept", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    check("stall_rsp_seen", seen, 1);
    check("stall_rsp_fields", {bus.rsp_id, bus.rsp_data, bus.rsp_num_err, bus.rsp_err, bus.rsp_timeout},
          {1'b0, 32'h0000_600D, 2'd1, 1'b0, 1'b0});
    snap = {bus.rsp_id, bus.rsp_data, bus.rsp_num_err, bus.rsp_err, bus.rsp_timeout};
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus.req_valid = 2'b10;
      @(negedge clk);
      if (!bus.rsp_valid || bus.req_ready != '0 ||
          {bus.rsp_id, bus.rsp_data, bus.rsp_num_err, bus.rsp_err, bus.rsp_timeout} != snap)
        bad++;
    end
    check("stall_hold_errs", bad, 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_handshake_cycle", {bus.rsp_valid, bus.req_ready}, 3'b100);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_next_grant", {bus.rsp_valid, bus.req_ready}, 3'b010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle("stall_final_idle");
  endtask

  task automatic reset_mid_test();
    int bad;
    @(posedge clk); #1;
    bus.req_op[1:0]    = 2'b01;
    bus.req_data[31:0] = 32'hCAFE_0001;
    bus.req_noise[31:0] = 32'h2;
    bus.operation_done = 1'b0;
    bus.req_valid = 2'b01;
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
    end
    check("rst_noise_access", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}, {3'b111, 20'hC});
    #1 rst = 1'b1;
    #1 check("rst_async_outputs", all_outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.busy || bus.PSEL || bus.rsp_valid) bad++;
    end
    check("rst_job_lost_errs", bad, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //            id op     wid    data          noise         prdata        core_out      nerr   done   resp   exp_data      exp_nerr        err  to
    vecs[0] = '{0, 2'b01, 2'b10, 32'hA5A5A5A5, 32'h00000001, 32'hA5A5A5A5, 32'h00005A5A, 2'd1, C+3,   C+4,  32'h00005A5A, 2'd1,           1'b0, 1'b0};
    vecs[1] = '{1, 2'b00, 2'b00, 32'h00000012, 32'h00000000, 32'h00000012, 32'h00003C3C, 2'd2, C+2,   C+3,  32'h00003C3C, 2'd0,           1'b0, 1'b0};
    vecs[2] = '{0, 2'b10, 2'b01, 32'h0000DEAD, 32'h80000001, 32'h0000DEAD, 32'h0000BEEF, 2'd3, 1,     C+3,  32'h0000BEEF, 2'd3,           1'b0, 1'b0};
    vecs[3] = '{1, 2'b11, 2'b10, 32'hFFFF0000, 32'h00000003, 32'hFFFF0000, 32'h00001234, 2'd1, 1,     1,    32'h00000000, 2'd0,           1'b1, 1'b0};
    vecs[4] = '{0, 2'b01, 2'b00, 32'h0000000F, 32'h00000002, 32'h0000000F, 32'h00000099, 2'd2, NEVER, C+17, 32'h00000000, 2'd0,           1'b0, 1'b1};
    vecs[5] = '{1, 2'b10, 2'b10, 32'h00000077, 32'h00000004, 32'h00000077, 32'h0000CAFE, 2'd2, C+16,  C+17, 32'h0000CAFE, 2'd2,           1'b0, 1'b0};
    vecs[6] = '{0, 2'b01, 2'b01, 32'h00000055, 32'h00000001, 32'h00000054, 32'h00000077, 2'd1, C+2,
                RB ? 9 : C+3, RB ? 32'h0 : 32'h77, RB ? 2'd0 : 2'd1, RB, 1'b0};

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_width = '0;
    bus.req_data  = '0;
    bus.req_noise = '0;
    bus.rsp_ready = 1'b1;
    bus.PRDATA    = '0;
    bus.data_out  = '0;
    bus.operation_done = 1'b0;
    bus.num_of_errors  = '0;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
    rr_test();
    stall_test();
    reset_mid_test();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
